mac_pipe: RTL and testbench
===========================

// Module: mac_pipe
// PURPOSE
//  Parametrised pipelined signed multiply-accumulate for the conv/FC datapath.
//  Multiplies a stream of signed operand pairs and accumulates them over a burst
//  delimited by in_first/in_last. Each burst produces one requantised result
//  (rounded arithmetic shift, saturated to OW bits).
//  Uses valid/ready on both sides; sits between the operand fetch and the output writeback.
// PARAMETERS
//  DW    9   operand width, signed two's complement
//  PIPE  2   multiplier pipeline stages, >=1
//  AW    32  accumulator width, >=2*DW
//  OW    16  result width, <=AW
//  SHW   5   width of the shift control
// PORTS
//  clk       in   1    single clock, rising edge
//  rst       in   1    synchronous, active-high reset
//  in_valid  in   1    operand beat valid
//  in_ready  out  1    beat accepted when in_valid&&in_ready
//  in_a      in   DW   signed operand A
//  in_b      in   DW   signed operand B
//  in_first  in   1    beat starts a new burst (accumulator is loaded, not added)
//  in_last   in   1    beat ends the burst (produces one result)
//  in_shift  in   SHW  right shift for requant; sampled only on the in_last beat
//  out_valid out  1    result valid
//  out_ready in   1    result consumed when out_valid&&out_ready
//  out_data  out  OW   signed requantised result
//  out_sat   out  1    result was clipped, qualified by out_valid
// BEHAVIOUR
//  Reset:
//   - All pipeline valid bits, acc, out_data, out_valid and out_sat go to 0.
//   - in_ready=0 while rst=1.
//   - Any burst in flight is discarded; no partial result is emitted.
//  Stall and in_ready:
//   - stall = out_valid && !out_ready.
//   - While stall=1 the whole pipeline, accumulator and output register hold.
//   - in_ready = !rst && !stall.
//  Multiplier and accumulator:
//   - Product is the full 2*DW-bit signed product, carried through PIPE registers.
//   - Each registered stage carries valid, first, last and shift alongside the product.
//   - Accumulate stage, on a valid product beat:
//     acc = first ? sext(prod) : acc + sext(prod).
//   - acc wraps modulo 2^AW; it is not saturated.
//   - A beat arriving with no preceding first (after reset) adds to acc=0.
//  Result on a last beat, computed in AW+1 bits:
//   - r = (s==0) ? acc : (acc + (1<<(s-1))) >>> s, i.e. round half toward +inf.
//   - If r > 2^(OW-1)-1: out_data = 2^(OW-1)-1, out_sat = 1.
//   - If r < -2^(OW-1):  out_data = -2^(OW-1), out_sat = 1.
//   - Otherwise out_data = r[OW-1:0], out_sat = 0.
//   - out_data and out_sat are registered; out_valid is set.
//  Output handshake:
//   - out_valid clears on out_ready unless a new last result lands in the same cycle.
//   - A new result may load in the same cycle the old one is consumed, giving full throughput.
//  first&&last on one beat: single-product result.
//  A first beat right after a last beat: new burst, no bubble.
//  Latency: last beat accepted in cycle t -> out_valid=1 in cycle t+PIPE+1, with no stall.
//  Throughput: one beat per cycle; out_data is stable while stall=1.
// STRUCTURE
//  mac_pkg:
//   - function rnd_sat(acc, shift) returning {sat, data}.
//   - localparam PW = 2*DW.
//  Sub-module smul_pipe #(DW,PIPE):
//   - Pipelined signed multiplier with enable (=!stall) and a sideband valid/tag bus.
//  mac_pipe holds the accumulator, rounding/saturation, output register and handshake.
// TESTING (DW=9, PIPE=2, AW=32, OW=16)
//  1. One beat, first=last=1, a=-256, b=-256, shift=0
//     -> accepted at t, out_valid at t+3, out_data=32767, out_sat=1.
//  2. Burst of 4 beats a=3, b=5, shift=2 on the last beat
//     -> acc=60, out_data=15 ((60+2)>>>2), out_sat=0.
//  3. One beat a=-3, b=1, shift=1
//     -> out_data=-1 (tie -1.5 rounds up).
//     Also a=-256, b=255, burst of 2, shift=0 -> -130560 clips to -32768, out_sat=1.
//  4. Hold out_ready=0 with a result pending while in_valid=1
//     -> in_ready=0, out_data stable, no beat lost.
//     Release -> the queued bursts' results emerge in order.
//  5. Raise rst for 1 cycle after 2 beats of a 4-beat burst
//     -> out_valid=0, no result for that burst.
//     A fresh burst a=2,b=2 x2, shift=0 -> out_data=8.
//  6. Back-to-back bursts A (3 beats a=1,b=1) and B (first=last, a=7,b=-2), out_ready=1
//     -> out_data 3 then -14 in consecutive cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
//   Shared definitions for the multiply-accumulate datapath: default widths,
//   the product width and the rounding/saturation helper used on the result
//   of every burst.
// ----------------------------------------------------------------------------
package mac_pkg;

    localparam int DEF_DW   = 9;
    localparam int DEF_PIPE = 2;
    localparam int DEF_AW   = 32;
    localparam int DEF_OW   = 16;
    localparam int DEF_SHW  = 5;

    // Full signed product width for the default operand width.
    localparam int PW = 2 * DEF_DW;

    // Working width of the rounding helper. It holds any accumulator of up to
    // 63 bits plus one guard bit, so the rounding add can never overflow.
    localparam int RW = 64;

    typedef struct packed {
        logic              sat;
        logic signed [RW-1:0] data;
    } rnd_sat_t;

    // Round half toward +inf with an arithmetic right shift, then clip to a
    // signed ow-bit range. acc must arrive sign-extended to RW bits.
    function automatic rnd_sat_t rnd_sat(input logic signed [RW-1:0] acc,
                                         input int unsigned          shift,
                                         input int unsigned          ow);
        logic signed [RW-1:0] r;
        logic signed [RW-1:0] hi;
        logic signed [RW-1:0] lo;
        rnd_sat_t             res;
        if (shift == 0)
            r = acc;
        else
            r = (acc + (RW'(1) << (shift - 1))) >>> shift;
        hi = (RW'(1) << (ow - 1)) - RW'(1);
        lo = -(RW'(1) << (ow - 1));
        res.sat = 1'b1;
        if (r > hi)
            res.data = hi;
        else if (r < lo)
            res.data = lo;
        else begin
            res.sat  = 1'b0;
            res.data = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/smul_pipe.sv
// ----------------------------------------------------------------------------
// smul_pipe
//   Pipelined signed multiplier. The full 2*DW-bit product and an opaque
//   sideband tag travel through PIPE register stages together with a valid
//   bit. All stages advance only while en=1.
// Ports
//   clk, rst   clock, synchronous active-high reset (clears valid bits only)
//   en         advance the pipeline
//   in_valid   operand pair is valid
//   in_a/in_b  signed operands, DW bits
//   in_tag     sideband carried alongside the product, TW bits
//   out_valid  product valid at the last stage
//   out_prod   signed product, 2*DW bits
//   out_tag    sideband matching out_prod
// ----------------------------------------------------------------------------
module smul_pipe #(
    parameter int DW   = 9,
    parameter int PIPE = 2,
    parameter int TW   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic signed [DW-1:0]   in_a,
    input  logic signed [DW-1:0]   in_b,
    input  logic [TW-1:0]          in_tag,
    output logic                   out_valid,
    output logic signed [2*DW-1:0] out_prod,
    output logic [TW-1:0]          out_tag
);

    localparam int MW = 2 * DW;

    logic                 vld_q  [PIPE];
    logic signed [MW-1:0] prod_q [PIPE];
    logic [TW-1:0]        tag_q  [PIPE];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++)
                vld_q[i] <= 1'b0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < PIPE; i++)
                vld_q[i] <= vld_q[i-1];
        end
    end

    // NOTE: the product/tag stages are plain data qualified by vld_q, so they
    // are left out of reset; only the valid bits need a known value.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_q[0] <= MW'(in_a) * MW'(in_b);
            tag_q[0]  <= in_tag;
            for (int i = 1; i < PIPE; i++) begin
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[PIPE-1];
    assign out_prod  = prod_q[PIPE-1];
    assign out_tag   = tag_q[PIPE-1];

endmodule

// File: rtl/mac_pipe.sv
// ----------------------------------------------------------------------------
// mac_pipe
//   Pipelined signed multiply-accumulate. Operand pairs are multiplied, then
//   accumulated over a burst framed by in_first/in_last. The last beat of a
//   burst produces one requantised result: rounded arithmetic right shift by
//   in_shift, saturated to OW bits. Valid/ready on both sides; a held output
//   stalls the whole pipeline.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand beat handshake
//   in_a, in_b      signed operands, DW bits
//   in_first        beat loads the accumulator instead of adding
//   in_last         beat closes the burst and produces a result
//   in_shift        requant right shift, used on the last beat only
//   out_valid/ready result handshake
//   out_data        signed requantised result, OW bits
//   out_sat         result was clipped
// ----------------------------------------------------------------------------
module mac_pipe
    import mac_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int PIPE = DEF_PIPE,
    parameter int AW   = DEF_AW,
    parameter int OW   = DEF_OW,
    parameter int SHW  = DEF_SHW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [SHW-1:0]       in_shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat
);

    localparam int MW = 2 * DW;
    localparam int TW = SHW + 2;

    logic                 stall;
    logic                 m_valid;
    logic signed [MW-1:0] m_prod;
    logic [TW-1:0]        m_tag;
    logic                 m_first;
    logic                 m_last;
    logic [SHW-1:0]       m_shift;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    rnd_sat_t             rs;
    logic                 unused_hi;

    // A result that is offered but not taken freezes everything upstream.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !rst && !stall;

    smul_pipe #(
        .DW   (DW),
        .PIPE (PIPE),
        .TW   (TW)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .in_valid  (in_valid && in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    ({in_first, in_last, in_shift}),
        .out_valid (m_valid),
        .out_prod  (m_prod),
        .out_tag   (m_tag)
    );

    assign {m_first, m_last, m_shift} = m_tag;

    // NOTE: every variable in this block is assigned on every path, so no
    // latch is inferred.
    always_comb begin
        acc_sum = m_first ? AW'(m_prod) : acc + AW'(m_prod);
        rs      = rnd_sat(RW'(acc_sum), 32'(m_shift), OW);
    end

    // Saturation already limits the value to OW bits; the upper bits are
    // copies of the sign and carry no information.
    assign unused_hi = ^rs.data[RW-1:OW];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            if (m_valid)
                acc <= acc_sum;
            // Not stalled means the held result (if any) is consumed now, so
            // a new result can replace it in the same cycle.
            if (m_valid && m_last) begin
                out_valid <= 1'b1;
                out_data  <= rs.data[OW-1:0];
                out_sat   <= rs.sat;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// ----------------------------------------------------------------------------
// tb_mac_pipe
//   Self-checking bench for mac_pipe (DW=9, PIPE=2, AW=32, OW=16, SHW=5).
//   The driver updates an arithmetic reference model on every accepted beat
//   and queues the expected result of each closed burst; a monitor pops and
//   compares whenever the DUT hands a result over.
// ----------------------------------------------------------------------------
module tb_mac_pipe;

    localparam int PW_T = mac_pkg::PW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [8:0] in_a;
    logic signed [8:0] in_b;
    logic              in_first;
    logic              in_last;
    logic [4:0]        in_shift;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] out_data;
    logic              out_sat;

    mac_pipe #(
        .DW   (9),
        .PIPE (2),
        .AW   (32),
        .OW   (16),
        .SHW  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     sat;
        int     acc_cyc;
        bit     chk_lat;
    } exp_t;

    exp_t   exp_q[$];
    int     pop_cyc_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint macc = 0;
    bit     rand_rdy = 1'b0;
    bit     lat_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requantisation from the arithmetic definition: floor((acc + 2^(s-1)) / 2^s)
    // with floor division built from truncating division, then clipped.
    function automatic exp_t model_result(input longint acc, input int s);
        longint num;
        longint d;
        longint q;
        exp_t   e;
        if (s == 0) begin
            q = acc;
        end else begin
            d   = longint'(1) << s;
            num = acc + d / 2;
            q   = num / d;
            if ((num % d != 0) && (num < 0))
                q = q - 1;
        end
        e.sat = 1'b1;
        if (q > 32767)
            e.data = 32767;
        else if (q < -32768)
            e.data = -32768;
        else begin
            e.data = q;
            e.sat  = 1'b0;
        end
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic model_accept(input int a, input int b, input bit f, input bit l, input int s);
        logic signed [PW_T-1:0] p;
        logic [63:0]            wide;
        exp_t                   e;
        p = PW_T'(a * b);
        if (f)
            macc = longint'(p);
        else
            macc = macc + longint'(p);
        // The accumulator wraps modulo 2^32.
        wide = macc;
        macc = longint'($signed(wide[31:0]));
        if (l) begin
            e         = model_result(macc, s);
            e.acc_cyc = cyc;
            e.chk_lat = lat_en && !rand_rdy;
            exp_q.push_back(e);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int a, input int b, input bit f, input bit l, input int s);
        int budget;
        budget = 0;
        @(negedge clk);
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_a     = 9'(a);
        in_b     = 9'(b);
        in_first = f;
        in_last  = l;
        in_shift = 5'(s);
        #1;
        while (!in_ready) begin
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL beat_accept_timeout waited=%0d cycles required<=200", budget);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            #1;
        end
        model_accept(a, b, f, l, s);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    // Monitor: compare every handed-over result, and watch stall behaviour.
    initial begin
        exp_t               e;
        bit                 prev_stall;
        logic signed [15:0] prev_data;
        logic               prev_sat;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_sat   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    check("in_ready_during_stall", longint'(in_ready), 0);
                    if (prev_stall) begin
                        check("stall_hold_data", longint'(out_data), longint'(prev_data));
                        check("stall_hold_sat", longint'(out_sat), longint'(prev_sat));
                    end
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                    prev_sat   = out_sat;
                end else begin
                    prev_stall = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result got=%0d expected no result", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", longint'(out_data), e.data);
                        check("out_sat", longint'(out_sat), longint'(e.sat));
                        if (e.chk_lat)
                            check("latency", longint'(cyc - e.acc_cyc), 3);
                        pop_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int len;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_shift  = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("post_rst_in_ready", longint'(in_ready), 1);

        // 1: single beat, positive overflow clip.
        send(-256, -256, 1'b1, 1'b1, 0);
        drain();

        // 2: 4-beat burst; shift on non-last beats must be ignored.
        for (int i = 0; i < 4; i++)
            send(3, 5, i == 0, i == 3, (i == 3) ? 2 : int'($urandom_range(0, 31)));
        drain();

        // 3: rounding tie toward +inf, and negative clip.
        send(-3, 1, 1'b1, 1'b1, 1);
        send(-256, 255, 1'b1, 1'b0, 0);
        send(-256, 255, 1'b0, 1'b1, 0);
        drain();

        // 4: hold the output while beats keep arriving.
        lat_en = 1'b0;
        @(negedge clk) out_ready = 1'b0;
        fork
            begin
                send(10, 10, 1'b1, 1'b0, 3);
                send(-7, 9, 1'b0, 1'b1, 3);
                send(100, -100, 1'b1, 1'b1, 4);
                send(1, 1, 1'b1, 1'b1, 0);
            end
            begin
                repeat (12) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        lat_en = 1'b1;

        // 5: reset in the middle of a burst discards it.
        send(5, 5, 1'b1, 1'b0, 0);
        send(5, 5, 1'b0, 1'b0, 0);
        @(negedge clk) rst = 1'b1;
        macc = 0;
        #1;
        check("mid_rst_in_ready", longint'(in_ready), 0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("mid_rst_out_valid", longint'(out_valid), 0);
        repeat (6) @(negedge clk);
        #1;
        check("mid_rst_no_result", longint'(out_valid), 0);
        send(2, 2, 1'b1, 1'b0, 0);
        send(2, 2, 1'b0, 1'b1, 0);
        drain();

        // 6: back-to-back bursts give results in consecutive cycles.
        pop_cyc_q.delete();
        send(1, 1, 1'b1, 1'b0, 0);
        send(1, 1, 1'b0, 1'b0, 0);
        send(1, 1, 1'b0, 1'b1, 0);
        send(7, -2, 1'b1, 1'b1, 0);
        drain();
        check("b2b_count", longint'(pop_cyc_q.size()), 2);
        if (pop_cyc_q.size() == 2)
            check("b2b_gap", longint'(pop_cyc_q[1] - pop_cyc_q[0]), 1);

        // Random bursts with random backpressure and input gaps.
        rand_rdy = 1'b1;
        repeat (60) begin
            len = int'($urandom_range(1, 5));
            for (int j = 0; j < len; j++) begin
                send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                     j == 0, j == len - 1, int'($urandom_range(0, 31)));
                if ($urandom_range(0, 3) == 0)
                    @(negedge clk);
            end
        end
        rand_rdy = 1'b0;
        @(negedge clk) out_ready = 1'b1;
        drain();

        check("queue_empty_at_end", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
